// File: rtl/sync_fifo_16x8.sv
// Single-clock 16x8 FIFO with occupancy count and sticky overflow/underflow flags.
// Storage is not reset; only pointers, count, read data and the error flags are.
module sync_fifo_16x8 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              wr_ok;
    logic              rd_ok;

    // A write is accepted when there is room, or when full and a read frees a slot
    // on the same edge. A read is accepted whenever something is stored.
    always_comb begin
        wr_ok = we & (~full | re);
        rd_ok = re & ~empty;
    end

    // Status flags come straight from the registered count.
    always_comb begin
        full  = (count == CNT_FULL);
        empty = (count == '0);
    end

    // Storage array; deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= data_in;
        end
    end

    // Pointers, count and registered read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok) begin
                rptr     <= rptr + PTR_ONE;
                data_out <= mem[rptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags. A write while full paired with a read is not an overflow,
    // and a read while empty paired with a write is not an underflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we & full & ~re) begin
                overflow <= 1'b1;
            end
            if (re & empty & ~we) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_16x8.sv
// Directed bench for sync_fifo_16x8: hand sequences for fill/drain/wrap/reset corners
// plus a table of mixed read/write vectors with hand-computed expectations.
module tb_sync_fifo_16x8;

    logic       clk;
    logic       rst;
    logic       we;
    logic       re;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] din;
        logic [4:0] cnt;
        logic [7:0] dout;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs [8];

    sync_fifo_16x8 dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .re        (re),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [4:0] c, input logic [7:0] d,
                           input logic f, input logic e, input logic o, input logic u);
        chk({name, " count"},     32'(count),     32'(c));
        chk({name, " data_out"},  32'(data_out),  32'(d));
        chk({name, " full"},      32'(full),      32'(f));
        chk({name, " empty"},     32'(empty),     32'(e));
        chk({name, " overflow"},  32'(overflow),  32'(o));
        chk({name, " underflow"}, 32'(underflow), 32'(u));
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        we      = w;
        re      = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        we  = 1'b0;
        re  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        data_in = 8'h00;

        vecs[0] = '{we:1, re:1, din:8'h66, cnt:5'd1, dout:8'hAF, full:0, empty:0, ovf:0, unf:0};
        vecs[1] = '{we:0, re:1, din:8'h00, cnt:5'd0, dout:8'h66, full:0, empty:1, ovf:0, unf:0};
        vecs[2] = '{we:1, re:0, din:8'h11, cnt:5'd1, dout:8'h66, full:0, empty:0, ovf:0, unf:0};
        vecs[3] = '{we:1, re:0, din:8'h22, cnt:5'd2, dout:8'h66, full:0, empty:0, ovf:0, unf:0};
        vecs[4] = '{we:1, re:1, din:8'h33, cnt:5'd2, dout:8'h11, full:0, empty:0, ovf:0, unf:0};
        vecs[5] = '{we:0, re:1, din:8'h00, cnt:5'd1, dout:8'h22, full:0, empty:0, ovf:0, unf:0};
        vecs[6] = '{we:0, re:1, din:8'h00, cnt:5'd0, dout:8'h33, full:0, empty:1, ovf:0, unf:0};
        vecs[7] = '{we:0, re:0, din:8'h00, cnt:5'd0, dout:8'h33, full:0, empty:1, ovf:0, unf:0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // fill plus one: 0x00..0x10, last one dropped
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk_all("fill", (i < 16) ? 5'(i + 1) : 5'd16, 8'h00,
                    (i >= 15), 1'b0, (i == 16), 1'b0);
        end

        // drain plus one
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk_all("drain", (i < 16) ? 5'(15 - i) : 5'd0, (i < 16) ? 8'(i) : 8'h0F,
                    1'b0, (i >= 15), 1'b1, (i == 16));
        end

        // wrap-around with fresh flags
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(8'h30 + i));
            chk_all("wrap_w10", 5'(i + 1), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk_all("wrap_r10", 5'(9 - i), 8'(8'h30 + i), 1'b0, (i == 9), 1'b0, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(8'hA0 + i));
            chk_all("wrap_w16", 5'(i + 1), 8'h39, (i == 15), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk_all("wrap_r16", 5'(15 - i), 8'(8'hA0 + i), 1'b0, (i == 15), 1'b0, 1'b0);
        end

        // table of mixed vectors starting from empty
        for (int k = 0; k < 8; k++) begin
            step(vecs[k].we, vecs[k].re, vecs[k].din);
            chk_all($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].dout,
                    vecs[k].full, vecs[k].empty, vecs[k].ovf, vecs[k].unf);
        end

        // simultaneous read/write while full
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(8'h70 + i));
        end
        chk_all("full_pre", 5'd16, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h55);
        chk_all("full_wr_rd", 5'd16, 8'h70, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk_all("full_drain", 5'(15 - i), (i < 15) ? 8'(8'h71 + i) : 8'h55,
                    1'b0, (i == 15), 1'b0, 1'b0);
        end

        // async reset mid-stream with count = 5
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'(8'hC0 + i));
        end
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk_all("pre_async", 5'd5, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        chk_all("post_rst", 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_16x8.md
Name: sync_fifo_16x8

Overview:
Single-clock synchronous FIFO buffer, 16 entries deep, 8 bits wide.
It decouples a byte producer from a byte consumer inside one clock domain.
It provides full and empty status, an occupancy count, and sticky overflow/underflow error flags.
Writes and reads are single-cycle, enable-qualified operations.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 16, number of storage entries (power of two)
ADDR_W, 4, pointer width, equal to log2(DEPTH)

Ports:
clk  input  1  rising-edge clock; all state changes on this edge
rst  input  1  asynchronous reset, active-low; clears all state immediately while low
we  input  1  write enable; sampled on rising clk
re  input  1  read enable; sampled on rising clk
data_in  input  DATA_W  write data; sampled when a write is accepted
data_out  output  DATA_W  registered read data
full  output  1  high when count == DEPTH
empty  output  1  high when count == 0
count  output  ADDR_W+1  number of stored entries, 0..16
overflow  output  1  sticky; set by a write attempted while full
underflow  output  1  sticky; set by a read attempted while empty

Behaviour:
- Reset (rst low, asynchronous):
  - write pointer = 0, read pointer = 0, count = 0.
  - data_out = 0x00, empty = 1, full = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all stored data immediately.
- Accepted write = we & ~full, or we & re & full (see simultaneous rules below).
  - On the edge: mem[wptr] <= data_in, wptr increments modulo 16.
- Accepted read = re & ~empty.
  - On the edge: data_out <= mem[rptr], rptr increments modulo 16.
  - Read latency is 1 cycle: data_out is valid right after the edge on which re was sampled.
- data_out holds its last value when no read is accepted, including a read while empty.
- count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- full and empty are derived from the registered count, so they update on the same edge as count.
- Order is strictly first-in first-out. Pointers wrap from 15 to 0 with no gap.
- Write while full (no accepted read): data is dropped, no state change, overflow <= 1.
- Read while empty: no state change, data_out held, underflow <= 1.
- Simultaneous we & re:
  - When empty: only the write is accepted. count becomes 1; the read is ignored but does not set underflow.
  - When full: both are accepted. The oldest entry goes to data_out, the new entry is stored, count stays 16, no overflow.
  - Otherwise: both are accepted and count is unchanged.
- overflow and underflow clear only on reset.
- All outputs are driven from registers; no combinational path from inputs to outputs.

Test Plan:
- Reset: drive rst low at time 0, then release -> empty=1, full=0, count=0, data_out=0x00, overflow=0, underflow=0.
- Fill plus one: write 17 bytes 0x00..0x10 on consecutive cycles ->
  - full rises on the edge of the 16th write; count=16.
  - The 17th byte (0x10) is dropped and overflow=1.
- Drain plus one: read 17 times ->
  - data_out shows 0x00..0x0F in order, each one cycle after its re edge.
  - empty rises with the 16th read.
  - The 17th read leaves data_out=0x0F and sets underflow=1.
- Wrap-around: write 10, read 10, then write 16 values 0xA0..0xAF and read all 16 -> identical order, full asserted at 16, pointers cross index 15->0 without error.
- Simultaneous access:
  - With count=16, assert we & re with data_in=0x55 -> oldest entry output, count stays 16, no overflow.
  - With count=0, assert we & re with data_in=0x66 -> count=1, underflow stays 0, data_out unchanged.
- Async reset mid-stream: with count=5, pull rst low between clock edges -> count=0, empty=1, data_out=0x00 immediately, without waiting for a clock edge.
